// File: rtl/instr_fetch_memory.sv
// ---------------------------------------------------------------------------
// instr_fetch_memory
//
// Parametrised instruction ROM for the fetch stage. A request is accepted in
// IDLE, optionally waits LATENCY cycles, then reads BEATS storage blocks
// (most-significant part first). The blocks are assembled into one 32-bit
// big-endian instruction, which is presented with a one-cycle Ack pulse.
// Misaligned or out-of-range requests answer after one cycle with AddrErr.
//
// Parameters:
//   WIDTH     storage block width: 16, 32 or 64 bits (64: upper half holds
//             the lower byte address, address[2] picks the half)
//   DEPTH     number of WIDTH-bit blocks
//   LATENCY   wait cycles before the first beat (0..15)
//   INIT_FILE image name (the ROM contents are provided by the environment)
//
// Ports:
//   CLK        clock, rising edge
//   RST_N      asynchronous active-low reset
//   address    byte address of the instruction
//   ReadEnable fetch request, accepted only while Ready=1
//   Abort      cancel an in-flight fetch (ignored in IDLE)
//   Ready      idle, a request can be accepted this cycle
//   Ack        one-cycle pulse, Instr/AddrErr valid
//   Instr      fetched instruction, holds until the next Ack
//   AddrErr    valid with Ack: misaligned or out-of-range request
//
// Optional build macro:
//   IMEM_LINE_BUFFER_EN  one-entry buffer of the last successful fetch; a
//                        repeated request to that address acks after one
//                        cycle, skipping WAIT/READ.
// ---------------------------------------------------------------------------
module instr_fetch_memory #(
  parameter int WIDTH     = 32,
  parameter int DEPTH     = 64,
  parameter int LATENCY   = 0,
  parameter     INIT_FILE = "testcase/memory/memory.data"
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic [31:0] address,
  input  logic        ReadEnable,
  input  logic        Abort,
  output logic        Ready,
  output logic        Ack,
  output logic [31:0] Instr,
  output logic        AddrErr
);

  localparam int BEATS = (WIDTH >= 32) ? 1 : 32 / WIDTH;
  localparam int BW    = 32 / BEATS;            // instruction bits per beat
  localparam int OFF   = $clog2(WIDTH / 8);     // byte offset bits per block
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_READ,
    S_ERR,
    S_HIT
  } state_t;

  logic [WIDTH-1:0] rom [DEPTH];

  state_t      state_reg;
  logic [3:0]  wait_cnt_reg;
  logic [1:0]  beat_cnt_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [31:0] buf_reg;

  logic        accept;
  logic [32:0] req_idx;
  logic        req_err;
  logic [WIDTH-1:0] blk;
  logic [BW-1:0]    beat_data;
  logic [31:0]      assembled;

  assign Ready  = (state_reg == S_IDLE);
  assign accept = Ready && ReadEnable;

  // 33-bit index so that index+BEATS-1 cannot wrap near the top of the map.
  assign req_idx = {1'b0, address} >> OFF;
  assign req_err = (address[1:0] != 2'b00) ||
                   (req_idx + 33'(BEATS - 1) >= 33'(DEPTH));

  // Block read from a registered pointer; the beat is registered into the
  // assembly buffer / Instr, giving a synchronous-read ROM.
  assign blk = rom[rd_ptr_reg];

  generate
    if (WIDTH == 64) begin : g_half
      logic half_reg;
      always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)
          half_reg <= 1'b0;
        else if (accept)
          half_reg <= address[2];
      end
      // Lower byte address lives in the upper half of the block.
      assign beat_data = half_reg ? blk[31:0] : blk[63:32];
    end else begin : g_full
      assign beat_data = blk;
    end
  endgenerate

  // Earlier beats shift toward the MSBs; with one beat the shift clears all.
  assign assembled = (buf_reg << BW) | 32'(beat_data);

`ifdef IMEM_LINE_BUFFER_EN
  logic        lb_valid_reg;
  logic [31:0] lb_addr_reg;
  logic [31:0] lb_instr_reg;
`endif

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 4'd0;
      beat_cnt_reg <= 2'd0;
      rd_ptr_reg   <= '0;
      buf_reg      <= 32'd0;
      Ack          <= 1'b0;
      AddrErr      <= 1'b0;
      Instr        <= 32'd0;
`ifdef IMEM_LINE_BUFFER_EN
      lb_valid_reg <= 1'b0;
      lb_addr_reg  <= 32'd0;
      lb_instr_reg <= 32'd0;
`endif
    end else begin
      Ack     <= 1'b0;
      AddrErr <= 1'b0;
      if (state_reg == S_IDLE) begin
        // Abort is meaningless in IDLE; a request is taken regardless.
        if (ReadEnable) begin
          rd_ptr_reg   <= req_idx[AW-1:0];
          beat_cnt_reg <= 2'd0;
          if (req_err) begin
            state_reg <= S_ERR;
          end
`ifdef IMEM_LINE_BUFFER_EN
          else if (lb_valid_reg && (lb_addr_reg == address)) begin
            state_reg <= S_HIT;
          end
`endif
          else if (LATENCY > 0) begin
            state_reg    <= S_WAIT;
            wait_cnt_reg <= 4'(LATENCY - 1);
          end else begin
            state_reg <= S_READ;
          end
        end
      end else if (Abort) begin
        state_reg    <= S_IDLE;
        wait_cnt_reg <= 4'd0;
        beat_cnt_reg <= 2'd0;
      end else begin
        case (state_reg)
          S_WAIT: begin
            if (wait_cnt_reg == 4'd0)
              state_reg <= S_READ;
            else
              wait_cnt_reg <= wait_cnt_reg - 4'd1;
          end
          S_READ: begin
            buf_reg    <= assembled;
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
            if (beat_cnt_reg == 2'(BEATS - 1)) begin
              state_reg    <= S_IDLE;
              beat_cnt_reg <= 2'd0;
              Ack          <= 1'b1;
              Instr        <= assembled;
`ifdef IMEM_LINE_BUFFER_EN
              lb_valid_reg <= 1'b1;
              lb_addr_reg  <= {rd_ptr_reg - AW'(BEATS - 1), OFF'(0)} ;
              lb_instr_reg <= assembled;
`endif
            end else begin
              beat_cnt_reg <= beat_cnt_reg + 2'd1;
            end
          end
          S_ERR: begin
            state_reg <= S_IDLE;
            Ack       <= 1'b1;
            AddrErr   <= 1'b1;
            Instr     <= 32'd0;
          end
`ifdef IMEM_LINE_BUFFER_EN
          S_HIT: begin
            state_reg <= S_IDLE;
            Ack       <= 1'b1;
            Instr     <= lb_instr_reg;
          end
`endif
          default: state_reg <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_instr_fetch_memory.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_memory
//
// Self-checking bench for instr_fetch_memory (WIDTH=16, DEPTH=64,
// LATENCY=2). The ROM image is random and mirrored in a bench-side array;
// expected instruction, error flag and Ack latency are computed from the
// address with plain arithmetic. Directed cases cover reset, abort, reset
// mid-read and the range boundaries, followed by a random request stream.
// ---------------------------------------------------------------------------
module tb_instr_fetch_memory;

  localparam int WIDTH   = 16;
  localparam int DEPTH   = 64;
  localparam int LATENCY = 2;
  localparam int BB      = WIDTH / 8;
  localparam int BEATS   = (WIDTH >= 32) ? 1 : 32 / WIDTH;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [31:0] address;
  logic        ReadEnable;
  logic        Abort;
  logic        Ready;
  logic        Ack;
  logic [31:0] Instr;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  logic [63:0] model_mem [DEPTH];
  logic [31:0] last_instr;
  bit          lb_valid;
  logic [31:0] lb_addr;

  instr_fetch_memory #(
    .WIDTH     (WIDTH),
    .DEPTH     (DEPTH),
    .LATENCY   (LATENCY),
    .INIT_FILE ("")
  ) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .address    (address),
    .ReadEnable (ReadEnable),
    .Abort      (Abort),
    .Ready      (Ready),
    .Ack        (Ack),
    .Instr      (Instr),
    .AddrErr    (AddrErr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One request from IDLE; returns in the Ack cycle so the next call is
  // back-to-back.
  task automatic fetch(input logic [31:0] a, input bit with_abort);
    longint      idx;
    bit          exp_err;
    bit          hit;
    int          exp_lat;
    int          n;
    logic [31:0] exp_instr;
    idx     = longint'(a) / BB;
    exp_err = (a[1:0] != 2'b00) || (idx + BEATS - 1 >= DEPTH);
    exp_instr = 32'd0;
    if (!exp_err) begin
      if (WIDTH == 64)
        exp_instr = a[2] ? model_mem[idx][31:0] : model_mem[idx][63:32];
      else
        for (int i = 0; i < BEATS; i++)
          exp_instr = (exp_instr << (32 / BEATS)) | 32'(model_mem[idx + i]);
    end
`ifdef IMEM_LINE_BUFFER_EN
    hit = !exp_err && lb_valid && (lb_addr == a);
`else
    hit = 1'b0;
`endif
    exp_lat = (exp_err || hit) ? 1 : LATENCY + BEATS;

    check("ready_before_req", {31'd0, Ready}, 32'd1);
    address    = a;
    ReadEnable = 1'b1;
    Abort      = with_abort;
    @(posedge CLK); #1;
    ReadEnable = 1'b0;
    Abort      = 1'b0;
    check("busy_after_accept", {31'd0, Ready}, 32'd0);
    n = 0;
    while (!Ack && n < 50) begin
      @(posedge CLK); #1;
      n++;
    end
    check("ack_latency", 32'(n), 32'(exp_lat));
    check("instr", Instr, exp_instr);
    check("addr_err", {31'd0, AddrErr}, {31'd0, exp_err});
    $display("fetch addr=0x%08h lat=%0d instr=0x%08h err=%0b", a, n, Instr, AddrErr);
    last_instr = exp_instr;
    if (!exp_err) begin
      lb_valid = 1'b1;
      lb_addr  = a;
    end
  endtask

  task automatic expect_no_ack(input string tag, input int cycles);
    int acks;
    acks = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge CLK); #1;
      if (Ack) acks++;
    end
    check(tag, 32'(acks), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] prev_a;
    int          r;

    RST_N      = 1'b0;
    address    = 32'd0;
    ReadEnable = 1'b0;
    Abort      = 1'b0;
    last_instr = 32'd0;
    lb_valid   = 1'b0;
    lb_addr    = 32'd0;

    for (int i = 0; i < DEPTH; i++) begin
      model_mem[i] = {$urandom, $urandom} & ((WIDTH == 64) ? 64'hFFFF_FFFF_FFFF_FFFF
                                                           : ((64'd1 << WIDTH) - 64'd1));
    end
    model_mem[4] = 64'h2408;
    model_mem[5] = 64'h0005;
    for (int i = 0; i < DEPTH; i++) dut.rom[i] = WIDTH'(model_mem[i]);

    // Reset state
    repeat (2) @(posedge CLK);
    #1;
    check("rst_ack", {31'd0, Ack}, 32'd0);
    check("rst_instr", Instr, 32'd0);
    check("rst_addr_err", {31'd0, AddrErr}, 32'd0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("rst_ready", {31'd0, Ready}, 32'd1);

    // Two-beat fetch with wait states
    fetch(32'h08, 1'b0);

    // Asynchronous reset in the middle of READ
    check("ready_before_rst_req", {31'd0, Ready}, 32'd1);
    address    = 32'h10;
    ReadEnable = 1'b1;
    @(posedge CLK); #1;
    ReadEnable = 1'b0;
    repeat (LATENCY) begin
      @(posedge CLK); #1;
    end
    #2;
    RST_N = 1'b0;
    #1;
    check("midrst_ack", {31'd0, Ack}, 32'd0);
    check("midrst_instr", Instr, 32'd0);
    check("midrst_addr_err", {31'd0, AddrErr}, 32'd0);
    last_instr = 32'd0;
    lb_valid   = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("midrst_ready", {31'd0, Ready}, 32'd1);
    expect_no_ack("midrst_stale_ack", 8);

    // Abort an in-flight fetch, then fetch normally
    fetch(32'h0C, 1'b0);
    address    = 32'h00;
    ReadEnable = 1'b1;
    @(posedge CLK); #1;
    ReadEnable = 1'b0;
    Abort      = 1'b1;
    @(posedge CLK); #1;
    Abort = 1'b0;
    check("abort_ready", {31'd0, Ready}, 32'd1);
    check("abort_ack", {31'd0, Ack}, 32'd0);
    check("abort_instr_held", Instr, last_instr);
    expect_no_ack("abort_no_ack", 8);
    check("abort_instr_still_held", Instr, last_instr);
    fetch(32'h04, 1'b0);

    // Errors and range boundaries
    fetch(32'h06, 1'b0);
    fetch(32'h100, 1'b0);
    fetch(32'(DEPTH * BB - 4), 1'b0);
    fetch(32'(DEPTH * BB), 1'b0);
    fetch(32'hFFFF_FFFC, 1'b0);

    // Repeated address (line-buffer path when enabled)
    fetch(32'h10, 1'b0);
    fetch(32'h10, 1'b0);
    fetch(32'h14, 1'b0);

    // Abort together with a request in IDLE is ignored
    fetch(32'h20, 1'b1);

    // Random request stream
    prev_a = 32'h20;
    for (int k = 0; k < 60; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6)
        a = 32'(4 * $urandom_range(0, DEPTH * BB / 4 - 1));
      else if (r == 6)
        a = 32'(4 * $urandom_range(0, DEPTH * BB / 4 - 1) + $urandom_range(1, 3));
      else if (r == 7)
        a = 32'(DEPTH * BB + 4 * $urandom_range(0, 15));
      else
        a = prev_a;
      fetch(a, ($urandom_range(0, 7) == 0));
      prev_a = a;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
